// File: rtl/mem_port_arbiter_pkg.sv
// mem_ctrl_pkg: shared definitions for the two-requester memory port arbiter.
//   - MS_2_0 size/sign encodings (BYTE .. WORDe) as seen by ram256x8_cREC
//   - FSM state enum (IDLE, ISSUE, WAIT, RESP, RECOVER)
//   - Grant encodings GNT_IF / GNT_DT
//   - lane_mask(): byte-lane mask for an access size in bytes
package mem_ctrl_pkg;

  localparam logic [2:0] MS_BYTE      = 3'b000;
  localparam logic [2:0] MS_HALFWORD  = 3'b001;
  localparam logic [2:0] MS_WORD      = 3'b010;
  localparam logic [2:0] MS_BYTEE     = 3'b100;
  localparam logic [2:0] MS_HALFWORDE = 3'b101;
  localparam logic [2:0] MS_WORDE     = 3'b110;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    RECOVER
  } state_e;

  // Low-order byte lanes that carry data for an access of the given size.
  function automatic logic [31:0] lane_mask(input logic [2:0] size_bytes);
    case (size_bytes)
      3'd1:    lane_mask = 32'h0000_00FF;
      3'd2:    lane_mask = 32'h0000_FFFF;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_check.sv
// mem_access_check: combinational range/alignment check of one memory request.
// Parameters:
//   ADDR_LIMIT   RAM size in bytes; the last byte touched must be below it.
// Ports:
//   addr_i        request byte address
//   ms_i          MS_2_0 size/sign code
//   legal_o       1 when the code is defined, aligned and fully in range
//   size_bytes_o  access size in bytes (1, 2 or 4)
module mem_access_check
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_LIMIT = 256
) (
  input  logic [31:0] addr_i,
  input  logic [2:0]  ms_i,
  output logic        legal_o,
  output logic [2:0]  size_bytes_o
);

  logic        code_ok;
  logic        aligned;
  logic [32:0] last_byte;

  always_comb begin
    code_ok      = 1'b1;
    aligned      = 1'b1;
    size_bytes_o = 3'd4;
    case (ms_i)
      MS_BYTE, MS_BYTEE: begin
        size_bytes_o = 3'd1;
      end
      MS_HALFWORD, MS_HALFWORDE: begin
        size_bytes_o = 3'd2;
        aligned      = (addr_i[0] == 1'b0);
      end
      MS_WORD, MS_WORDE: begin
        size_bytes_o = 3'd4;
        aligned      = (addr_i[1:0] == 2'b00);
      end
      default: begin
        // 011 / 111 have no meaning to the RAM.
        code_ok = 1'b0;
      end
    endcase
  end

  // Computed one bit wider so addresses near 2^32 cannot wrap into range.
  assign last_byte = {1'b0, addr_i} + {30'd0, size_bytes_o} - 33'd1;
  assign legal_o   = code_ok && aligned && (last_byte < 33'(ADDR_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported ram256x8_cREC between the
// instruction-fetch (IF, word reads) and data-transfer (DT) requesters.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN -- when defined, a conflict in
// IDLE is won by the requester not granted last; otherwise DT always wins.
// Parameters: TIMEOUT (cycles in WAIT before abort), ADDR_LIMIT (RAM bytes).
// Ports:
//   CLK, Reset                 clock, asynchronous active-high reset
//   IF_Req/IF_Addr             fetch request (always WORD read)
//   IF_Ack/IF_Data/IF_Err      fetch completion pulse, data, error
//   DT_Req/DT_RW/DT_MS/DT_Addr/DT_WData   data request
//   DT_Ack/DT_RData/DT_Err     data completion pulse, read data, error
//   MOV/ReadWrite/MS_2_0/Address/DataIn/MOCoff  registered RAM controls
//   MOC/DataOut                RAM completion and read data
//   Busy                       high whenever the FSM is not in IDLE
//   Grant                      current/last owner (0 = IF, 1 = DT)
module mem_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT    = 16,
  parameter int ADDR_LIMIT = 256
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  output logic        IF_Ack,
  output logic [31:0] IF_Data,
  output logic        IF_Err,
  input  logic        DT_Req,
  input  logic        DT_RW,
  input  logic [2:0]  DT_MS,
  input  logic [31:0] DT_Addr,
  input  logic [31:0] DT_WData,
  output logic        DT_Ack,
  output logic [31:0] DT_RData,
  output logic        DT_Err,
  output logic        MOV,
  output logic        ReadWrite,
  output logic [2:0]  MS_2_0,
  output logic [31:0] Address,
  output logic [31:0] DataIn,
  output logic        MOCoff,
  input  logic        MOC,
  input  logic [31:0] DataOut,
  output logic        Busy,
  output logic        Grant
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_e             state_q;
  logic               gnt_q;
  logic [31:0]        addr_q;
  logic [2:0]         ms_q;
  logic               rw_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               resp_err_q;
  logic [31:0]        resp_data_q;

  logic               mov_q;
  logic               rw_out_q;
  logic [2:0]         ms_out_q;
  logic [31:0]        address_q;
  logic [31:0]        datain_q;
  logic               if_ack_q;
  logic [31:0]        if_data_q;
  logic               if_err_q;
  logic               dt_ack_q;
  logic [31:0]        dt_rdata_q;
  logic               dt_err_q;

  logic               pick_dt;
  logic               chk_legal;
  logic [2:0]         chk_size;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a conflict the requester that did not own the port last wins.
  always_comb begin
    pick_dt = DT_Req;
    if (DT_Req && IF_Req) begin
      pick_dt = (gnt_q == GNT_IF);
    end
  end
`else
  always_comb begin
    pick_dt = DT_Req;
  end
`endif

  // Checks the latched request, so the verdict is available in ISSUE.
  mem_access_check #(
    .ADDR_LIMIT(ADDR_LIMIT)
  ) u_check (
    .addr_i      (addr_q),
    .ms_i        (ms_q),
    .legal_o     (chk_legal),
    .size_bytes_o(chk_size)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      addr_q      <= '0;
      ms_q        <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
      mov_q       <= 1'b0;
      rw_out_q    <= 1'b0;
      ms_out_q    <= '0;
      address_q   <= '0;
      datain_q    <= '0;
      if_ack_q    <= 1'b0;
      if_data_q   <= '0;
      if_err_q    <= 1'b0;
      dt_ack_q    <= 1'b0;
      dt_rdata_q  <= '0;
      dt_err_q    <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      dt_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (IF_Req || DT_Req) begin
            gnt_q   <= pick_dt ? GNT_DT : GNT_IF;
            addr_q  <= pick_dt ? DT_Addr : IF_Addr;
            ms_q    <= pick_dt ? DT_MS : MS_WORD;
            rw_q    <= pick_dt ? DT_RW : 1'b1;
            wdata_q <= pick_dt ? DT_WData : 32'd0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (chk_legal) begin
            address_q <= addr_q;
            ms_out_q  <= ms_q;
            rw_out_q  <= rw_q;
            // Lanes outside the access size are zeroed so the RAM never
            // sees stale upper bytes on narrow writes.
            datain_q  <= wdata_q & lane_mask(chk_size);
            mov_q     <= 1'b1;
            cnt_q     <= '0;
            state_q   <= WAIT;
          end else begin
            // Illegal request: answer with an error, RAM untouched.
            resp_err_q  <= 1'b1;
            resp_data_q <= '0;
            state_q     <= RESP;
          end
        end
        WAIT: begin
          if (MOC) begin
            mov_q       <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_data_q <= rw_q ? DataOut : 32'd0;
            state_q     <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            mov_q       <= 1'b0;
            resp_err_q  <= 1'b1;
            resp_data_q <= '0;
            state_q     <= RESP;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (gnt_q == GNT_DT) begin
            dt_ack_q   <= 1'b1;
            dt_rdata_q <= resp_data_q;
            dt_err_q   <= resp_err_q;
          end else begin
            if_ack_q  <= 1'b1;
            if_data_q <= resp_data_q;
            if_err_q  <= resp_err_q;
          end
          state_q <= RECOVER;
        end
        RECOVER: begin
          // Wait for the RAM to release MOC so accesses never overlap.
          if (!MOC) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign IF_Ack    = if_ack_q;
  assign IF_Data   = if_data_q;
  assign IF_Err    = if_err_q;
  assign DT_Ack    = dt_ack_q;
  assign DT_RData  = dt_rdata_q;
  assign DT_Err    = dt_err_q;
  assign MOV       = mov_q;
  assign ReadWrite = rw_out_q;
  assign MS_2_0    = ms_out_q;
  assign Address   = address_q;
  assign DataIn    = datain_q;
  assign MOCoff    = 1'b0;
  assign Busy      = (state_q != IDLE);
  assign Grant     = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural big-endian RAM.
// Stimulus pushes expected acks into a queue; a monitor pops and compares.
module tb_mem_port_arbiter;
  import mem_ctrl_pkg::*;

  logic        CLK;
  logic        Reset;
  logic        IF_Req;
  logic [31:0] IF_Addr;
  logic        IF_Ack;
  logic [31:0] IF_Data;
  logic        IF_Err;
  logic        DT_Req;
  logic        DT_RW;
  logic [2:0]  DT_MS;
  logic [31:0] DT_Addr;
  logic [31:0] DT_WData;
  logic        DT_Ack;
  logic [31:0] DT_RData;
  logic        DT_Err;
  logic        MOV;
  logic        ReadWrite;
  logic [2:0]  MS_2_0;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic        MOCoff;
  logic        MOC;
  logic [31:0] DataOut;
  logic        Busy;
  logic        Grant;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.TIMEOUT(16), .ADDR_LIMIT(256)) dut (
    .CLK(CLK), .Reset(Reset),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Ack(IF_Ack), .IF_Data(IF_Data), .IF_Err(IF_Err),
    .DT_Req(DT_Req), .DT_RW(DT_RW), .DT_MS(DT_MS), .DT_Addr(DT_Addr), .DT_WData(DT_WData),
    .DT_Ack(DT_Ack), .DT_RData(DT_RData), .DT_Err(DT_Err),
    .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0), .Address(Address), .DataIn(DataIn),
    .MOCoff(MOCoff), .MOC(MOC), .DataOut(DataOut), .Busy(Busy), .Grant(Grant)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- behavioural RAM: MOC rises 2 cycles after MOV ----------
  logic [7:0] mem [256];
  logic       moc_stuck;
  logic       do_preload;
  int         moc_cnt;

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      MOC     <= 1'b0;
      moc_cnt <= 0;
      DataOut <= '0;
      if (do_preload) begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[0]    <= 8'h12; mem[1]    <= 8'h34; mem[2]    <= 8'h56; mem[3]    <= 8'h78;
        mem[8'h40] <= 8'hDE; mem[8'h41] <= 8'hAD; mem[8'h42] <= 8'hBE; mem[8'h43] <= 8'hEF;
      end
    end else if (!MOV) begin
      MOC     <= 1'b0;
      moc_cnt <= 0;
    end else if (!MOC && !moc_stuck) begin
      if (moc_cnt == 1) begin
        MOC <= 1'b1;
        if (ReadWrite) begin
          case (MS_2_0[1:0])
            2'b00:   DataOut <= MS_2_0[2] ? {{24{mem[Address[7:0]][7]}}, mem[Address[7:0]]}
                                          : {24'd0, mem[Address[7:0]]};
            2'b01:   DataOut <= {16'd0, mem[Address[7:0]], mem[8'(Address[7:0] + 8'd1)]};
            default: DataOut <= {mem[Address[7:0]], mem[8'(Address[7:0] + 8'd1)],
                                 mem[8'(Address[7:0] + 8'd2)], mem[8'(Address[7:0] + 8'd3)]};
          endcase
        end else begin
          case (MS_2_0[1:0])
            2'b00: mem[Address[7:0]] <= DataIn[7:0];
            2'b01: begin
              mem[Address[7:0]]                 <= DataIn[15:8];
              mem[8'(Address[7:0] + 8'd1)]      <= DataIn[7:0];
            end
            default: begin
              mem[Address[7:0]]                 <= DataIn[31:24];
              mem[8'(Address[7:0] + 8'd1)]      <= DataIn[23:16];
              mem[8'(Address[7:0] + 8'd2)]      <= DataIn[15:8];
              mem[8'(Address[7:0] + 8'd3)]      <= DataIn[7:0];
            end
          endcase
        end
      end else begin
        moc_cnt <= moc_cnt + 1;
      end
    end
  end

  // ---------------- MOV observation ----------------
  int   mov_cycles;
  logic last_rw;
  always @(negedge CLK) begin
    if (MOV) begin
      mov_cycles = mov_cycles + 1;
      last_rw    = ReadWrite;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;
  exp_t sb[$];

  function automatic void expect_ack(logic port, logic [31:0] d, logic e, string nm);
    exp_t x;
    x.port = port; x.data = d; x.err = e; x.name = nm;
    sb.push_back(x);
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void observe(logic port, logic [31:0] d, logic e);
    exp_t x;
    $display("ack port=%s data=%08h err=%0d", port ? "DT" : "IF", d, e);
    if (sb.size() == 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL unexpected_ack actual=port%0d required=none", port);
    end else begin
      x = sb.pop_front();
      chk({x.name, "_port"}, 64'(port), 64'(x.port));
      chk({x.name, "_data"}, 64'(d), 64'(x.data));
      chk({x.name, "_err"},  64'(e), 64'(x.err));
    end
  endfunction

  always @(negedge CLK) begin
    if (!Reset) begin
      if (IF_Ack) observe(1'b0, IF_Data, IF_Err);
      if (DT_Ack) observe(1'b1, DT_RData, DT_Err);
    end
  end

  // ---------------- requester tasks (start and end on a negedge) ----------
  task automatic dt_txn(input logic rw, input logic [2:0] ms, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    bit got = 0;
    DT_RW = rw; DT_MS = ms; DT_Addr = addr; DT_WData = wdata; DT_Req = 1'b1;
    lat = 0;
    while (!got && lat < 200) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
      if (DT_Ack) got = 1;
    end
    if (!got) chk("dt_ack_timeout", 64'(lat), 64'd0);
    DT_Req = 1'b0;
  endtask

  task automatic if_txn(input logic [31:0] addr, output int lat);
    bit got = 0;
    IF_Addr = addr; IF_Req = 1'b1;
    lat = 0;
    while (!got && lat < 200) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
      if (IF_Ack) got = 1;
    end
    if (!got) chk("if_ack_timeout", 64'(lat), 64'd0);
    IF_Req = 1'b0;
  endtask

  task automatic gap;
    repeat (3) @(negedge CLK);
    mov_cycles = 0;
  endtask

  int lat, lat_a, lat_b;

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; do_preload = 1'b1; moc_stuck = 1'b0;
    IF_Req = 0; IF_Addr = 0; DT_Req = 0; DT_RW = 0; DT_MS = 0; DT_Addr = 0; DT_WData = 0;
    mov_cycles = 0; last_rw = 0;
    repeat (3) @(negedge CLK);
    do_preload = 1'b0;
    chk("reset_ctrl", 64'({MOV, Busy, Grant, IF_Ack, DT_Ack, ReadWrite, MOCoff, IF_Err, DT_Err}), 64'd0);
    chk("reset_bus", 64'(Address | DataIn | IF_Data | DT_RData | 32'(MS_2_0)), 64'd0);
    Reset = 1'b0;
    gap();

    // IF fetch: Ack after edge 5 (MOC seen on edge 4), MOV high 3 cycles.
    expect_ack(GNT_IF, 32'h12345678, 1'b0, "if_fetch");
    if_txn(32'h0, lat);
    chk("if_fetch_lat", 64'(lat), 64'd6);
    chk("if_fetch_mov", 64'(mov_cycles), 64'd3);
    gap();

    // Conflict 1 (last owner IF): DT first in both builds.
    expect_ack(GNT_DT, 32'h0000DEAD, 1'b0, "conf1_dt");
    expect_ack(GNT_IF, 32'hDEADBEEF, 1'b0, "conf1_if");
    fork
      if_txn(32'h40, lat_a);
      dt_txn(1'b1, MS_HALFWORD, 32'h40, 32'h0, lat_b);
    join
    gap();

    // DT byte write then read back.
    expect_ack(GNT_DT, 32'h0, 1'b0, "wr_byte");
    dt_txn(1'b0, MS_BYTE, 32'd20, 32'hAABBCCEE, lat);
    chk("wr_byte_rw", 64'(last_rw), 64'd0);
    chk("wr_byte_lat", 64'(lat), 64'd6);
    gap();
    expect_ack(GNT_DT, 32'h000000EE, 1'b0, "rd_byte");
    dt_txn(1'b1, MS_BYTE, 32'd20, 32'h0, lat);
    chk("rd_byte_rw", 64'(last_rw), 64'd1);
    chk("grant_dt", 64'(Grant), 64'(GNT_DT));
    gap();

    // Conflict 2 (last owner DT).
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expect_ack(GNT_IF, 32'hDEADBEEF, 1'b0, "conf2_if");
    expect_ack(GNT_DT, 32'h0000DEAD, 1'b0, "conf2_dt");
`else
    expect_ack(GNT_DT, 32'h0000DEAD, 1'b0, "conf2_dt");
    expect_ack(GNT_IF, 32'hDEADBEEF, 1'b0, "conf2_if");
`endif
    fork
      if_txn(32'h40, lat_a);
      dt_txn(1'b1, MS_HALFWORD, 32'h40, 32'h0, lat_b);
    join
    gap();

    // Illegal requests: Ack after edge 2, no MOV.
    expect_ack(GNT_DT, 32'h0, 1'b1, "ill_half201");
    dt_txn(1'b1, MS_HALFWORD, 32'd201, 32'h0, lat);
    chk("ill_half201_lat", 64'(lat), 64'd3);
    chk("ill_half201_mov", 64'(mov_cycles), 64'd0);
    gap();
    expect_ack(GNT_DT, 32'h0, 1'b1, "ill_word254");
    dt_txn(1'b0, MS_WORD, 32'd254, 32'h12345678, lat);
    chk("ill_word254_lat", 64'(lat), 64'd3);
    chk("ill_word254_mov", 64'(mov_cycles), 64'd0);
    gap();
    expect_ack(GNT_DT, 32'h0, 1'b1, "ill_ms011");
    dt_txn(1'b1, 3'b011, 32'd0, 32'h0, lat);
    chk("ill_ms011_mov", 64'(mov_cycles), 64'd0);
    gap();

    // Last legal word (bytes 252..255).
    expect_ack(GNT_DT, 32'h0, 1'b0, "wr_word252");
    dt_txn(1'b0, MS_WORD, 32'd252, 32'hCAFEF00D, lat);
    gap();
    expect_ack(GNT_DT, 32'hCAFEF00D, 1'b0, "rd_word252");
    dt_txn(1'b1, MS_WORD, 32'd252, 32'h0, lat);
    gap();

    // Timeout: MOC never rises; Ack after edge 18, MOV high 16 cycles.
    moc_stuck = 1'b1;
    expect_ack(GNT_DT, 32'h0, 1'b1, "timeout");
    dt_txn(1'b1, MS_WORD, 32'd8, 32'h0, lat);
    chk("timeout_lat", 64'(lat), 64'd19);
    chk("timeout_mov", 64'(mov_cycles), 64'd16);
    chk("timeout_mov_low", 64'(MOV), 64'd0);
    moc_stuck = 1'b0;
    gap();
    expect_ack(GNT_DT, 32'h000000EE, 1'b0, "after_timeout");
    dt_txn(1'b1, MS_BYTE, 32'd20, 32'h0, lat);
    gap();

    // Reset while in WAIT: MOV drops immediately, no Ack.
    moc_stuck = 1'b1;
    DT_RW = 1'b1; DT_MS = MS_BYTE; DT_Addr = 32'd20; DT_Req = 1'b1;
    repeat (5) @(negedge CLK);
    chk("wait_mov_high", 64'(MOV), 64'd1);
    #2 Reset = 1'b1;
    #1;
    chk("rst_mov_async", 64'(MOV), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    DT_Req = 1'b0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    moc_stuck = 1'b0;
    gap();
    expect_ack(GNT_DT, 32'h000000EE, 1'b0, "after_reset");
    dt_txn(1'b1, MS_BYTE, 32'd20, 32'h0, lat);
    chk("after_reset_lat", 64'(lat), 64'd6);
    gap();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
